// File: rtl/seq_gen_if.sv
// seq_gen control and serial-link bundle.
// Driver side is master, transmitter side is slave.
interface seq_gen_if #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 4
);
    logic               start;
    logic               abort;
    logic [MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0]   len;
    logic [CNT_W-1:0]   reps;
    logic [CNT_W-1:0]   gap;
    logic               x_out;
    logic               x_valid;
    logic               sof;
    logic               busy;
    logic               done;
    logic               err;

    modport master (
        output start, abort, pattern, len, reps, gap,
        input  x_out, x_valid, sof, busy, done, err
    );

    modport slave (
        input  start, abort, pattern, len, reps, gap,
        output x_out, x_valid, sof, busy, done, err
    );
endinterface

// File: rtl/seq_gen.sv
// Serial bit-pattern transmitter, MSB-first, with repeats and gaps.
// Start/busy/done handshake; all outputs registered.
module seq_gen #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 4
) (
    input logic   clk,
    input logic   rst,
    seq_gen_if.slave bus
);
    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

    state_t             state;
    logic [MAX_LEN-1:0] pat_q;
    logic [IDX_W-1:0]   first_q;
    logic [IDX_W-1:0]   bit_idx;
    logic [CNT_W-1:0]   reps_left;
    logic [CNT_W-1:0]   gap_q;
    logic [CNT_W-1:0]   gap_cnt;

    logic x_out_q;
    logic x_valid_q;
    logic sof_q;
    logic busy_q;
    logic done_q;
    logic err_q;

    logic             len_ok;
    logic [IDX_W-1:0] first_in;

    assign len_ok   = (bus.len != '0) &&
                      (bus.len <= LEN_W'(MAX_LEN));
    assign first_in = IDX_W'(bus.len - LEN_W'(1));

    assign bus.x_out   = x_out_q;
    assign bus.x_valid = x_valid_q;
    assign bus.sof     = sof_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;

    // Frame sequencer: state, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pat_q     <= '0;
            first_q   <= '0;
            bit_idx   <= '0;
            reps_left <= '0;
            gap_q     <= '0;
            gap_cnt   <= '0;
            x_out_q   <= 1'b0;
            x_valid_q <= 1'b0;
            sof_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            sof_q  <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state)
                IDLE: begin
                    x_out_q   <= 1'b0;
                    x_valid_q <= 1'b0;
                    busy_q    <= 1'b0;
                    if (bus.start && len_ok) begin
                        pat_q     <= bus.pattern;
                        first_q   <= first_in;
                        bit_idx   <= first_in;
                        reps_left <= bus.reps;
                        gap_q     <= bus.gap;
                        x_out_q   <= bus.pattern[first_in];
                        x_valid_q <= 1'b1;
                        sof_q     <= 1'b1;
                        busy_q    <= 1'b1;
                        state     <= SEND;
                    end else if (bus.start) begin
                        err_q <= 1'b1;
                    end
                end
                SEND: begin
                    if (bus.abort) begin
                        state     <= IDLE;
                        x_out_q   <= 1'b0;
                        x_valid_q <= 1'b0;
                        busy_q    <= 1'b0;
                    end else if (bit_idx != '0) begin
                        bit_idx <= bit_idx - 1'b1;
                        x_out_q <= pat_q[bit_idx - 1'b1];
                    end else if (reps_left == '0) begin
                        state     <= DONE;
                        x_out_q   <= 1'b0;
                        x_valid_q <= 1'b0;
                        done_q    <= 1'b1;
                    end else begin
                        reps_left <= reps_left - 1'b1;
                        if (gap_q == '0) begin
                            bit_idx <= first_q;
                            x_out_q <= pat_q[first_q];
                            sof_q   <= 1'b1;
                        end else begin
                            state     <= GAP;
                            gap_cnt   <= gap_q;
                            x_out_q   <= 1'b0;
                            x_valid_q <= 1'b0;
                        end
                    end
                end
                GAP: begin
                    if (bus.abort) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else if (gap_cnt == CNT_W'(1)) begin
                        state     <= SEND;
                        bit_idx   <= first_q;
                        x_out_q   <= pat_q[first_q];
                        x_valid_q <= 1'b1;
                        sof_q     <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/seq_gen.md
Name: seq_gen

Overview:
Serial bit-pattern transmitter. It shifts a programmable pattern out on a one-bit line, MSB-first, with optional repetition and idle gaps between repetitions. It is the driving end of the serial link consumed by the team's sequence detectors, and is used as the stimulus source in system benches and on-board self-test. Control is a start/busy/done handshake.

Parameters:
MAX_LEN, 8, maximum pattern length in bits.
LEN_W, 4, width of len; must hold MAX_LEN.
CNT_W, 4, width of repeat count and gap count.

Ports:
clk  input  1  clock; all state changes on rising edge.
rst  input  1  reset, asynchronous, active-high.
start  input  1  request a transmission; sampled only in IDLE.
abort  input  1  synchronous abort of the transmission in progress.
pattern  input  MAX_LEN  bits to send; bit len-1 is sent first, bit 0 last.
len  input  LEN_W  number of bits per frame; legal range 1..MAX_LEN.
reps  input  CNT_W  extra repetitions; frames sent = reps+1.
gap  input  CNT_W  idle cycles between frames; 0 means back-to-back.
x_out  output  1  serial data; 0 whenever x_valid=0.
x_valid  output  1  x_out carries a pattern bit this cycle.
sof  output  1  high together with the first bit of every frame.
busy  output  1  high from the accepting edge until IDLE is re-entered.
done  output  1  one-cycle pulse after the final bit of the final frame.
err  output  1  one-cycle pulse when start is rejected for an illegal len.

Behaviour:
- All outputs are registered. Reset (async) forces state=IDLE and clears all internal registers. Every output is 0 during and after reset.
- States: IDLE, SEND, GAP, DONE.
- IDLE, start=1, len in 1..MAX_LEN:
  - At that edge, latch pattern, len, reps and gap.
  - Set bit_idx=len-1 and state=SEND. Drive x_out=pattern[len-1], x_valid=1, sof=1, busy=1.
  - So the first bit is visible in the cycle right after the sampling edge; zero extra latency.
- IDLE, start=1, len=0 or len>MAX_LEN: stay IDLE, err=1 for one cycle, busy stays 0.
- SEND: one bit per cycle. bit_idx decrements; x_out=pattern_reg[bit_idx]; sof=0 after the first bit.
- After the bit at bit_idx=0, the next state depends on the remaining repetitions:
  - reps_left=0: go to DONE.
  - reps_left>0 and gap=0: decrement reps_left, reload bit_idx=len-1, stay in SEND with sof=1. No bubble between frames.
  - reps_left>0 and gap>0: decrement reps_left, go to GAP with x_valid=0 and x_out=0.
- GAP: lasts exactly gap cycles (counter loaded with gap, counts down), then SEND with the first bit and sof=1.
- DONE: lasts one cycle with done=1, busy=1, x_valid=0. Next state is IDLE with busy=0. A start arriving in the DONE cycle is ignored; start is accepted from the first IDLE cycle onward.
- start while busy is ignored. The latched pattern, len, reps and gap are immune to input changes mid-transmission.
- abort=1 in SEND, GAP or DONE:
  - Next edge goes to IDLE with x_valid=0, busy=0, no done pulse. A partially sent frame is not completed.
  - abort in IDLE has no effect. If abort=1 and start=1 in the same IDLE cycle, start wins.
- rst mid-transmission: immediate return to IDLE and all outputs 0. No done or err pulse.
- Total busy cycles for a legal start: (reps+1)*len + reps*gap + 1 (the DONE cycle).
- len=1 is legal: every frame is a single bit with sof=1.

Test Plan:
- pattern=8'b00000101, len=3, reps=0, gap=0, start pulse -> x_out 1,0,1 with x_valid=1 for 3 cycles and sof on the first; done=1 in cycle 4; busy high for 4 cycles. A connected "101" detector must raise its match output on the third bit.
- pattern=3'b101, len=3, reps=2, gap=2 -> 1,0,1, 2 idle, 1,0,1, 2 idle, 1,0,1, then done; sof high 3 times; busy=14 cycles.
- reps=1, gap=0, pattern=1101, len=4 -> 1,1,0,1,1,1,0,1 contiguous; sof on bits 1 and 5; x_valid never drops.
- start with len=0, then with len=9 -> err pulses once each; busy, x_valid and done stay 0.
- Mid-frame: assert start again and change pattern -> output unaffected. Then assert abort -> next cycle x_valid=0, busy=0, no done.
- rst asserted asynchronously mid-GAP -> all outputs 0 immediately. After release, a new start sends correctly from bit len-1.
